// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM states, exception codes, stall vectors and perf select codes
package pipe_ctrl_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_t;
  localparam logic [31:0] EXC_INTERRUPT    = 32'h1;
  localparam logic [31:0] EXC_SYSCALL      = 32'h8;
  localparam logic [31:0] EXC_INST_INVALID = 32'ha;
  localparam logic [31:0] EXC_TRAP         = 32'hd;
  localparam logic [31:0] EXC_OV           = 32'hc;
  localparam logic [31:0] EXC_ERET         = 32'he;
  localparam logic [5:0] StallNone      = 6'b000000;
  localparam logic [5:0] StallFromIF_ID = 6'b000111;
  localparam logic [5:0] StallFromEX    = 6'b001111;
  localparam logic [5:0] StallFromMEM   = 6'b011111;
  localparam logic [1:0] PERF_STALL = 2'd0;
  localparam logic [1:0] PERF_FLUSH = 2'd1;
  localparam logic [1:0] PERF_RUN   = 2'd2;
  localparam logic [1:0] PERF_ZERO  = 2'd3;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : (inc && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush arbitration with post-flush recovery, stall watchdog and perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wd_clr_i,
  input  logic [1:0]  perf_sel_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wd_timeout_o,
  output logic [31:0] perf_data_o
);
  state_t state, state_nx;
  logic exc;
  logic [CNT_W-1:0] stall_cnt;
  logic [15:0] flush_cnt, run_cnt;
  logic [31:0] perf_q;
  logic wd_set;
  assign exc = excepttype_i != '0;
  always_ff @(posedge clk)
    state <= rst ? ST_RUN : state_nx;
  always_comb
    state_nx = (state == ST_RUN && exc) ? ST_RECOVER : ST_RUN;
  always_comb begin
    flush  = !rst && state == ST_RUN && exc;
    new_pc = !flush ? '0 : (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    stall  = (rst || state != ST_RUN || exc) ? StallNone :
             stallreq_from_mem ? StallFromMEM :
             stallreq_from_ex  ? StallFromEX :
             (stallreq_from_id || stallreq_from_if) ? StallFromIF_ID : StallNone;
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall[0]), .clr(1'b0), .q(stall_cnt));
  sat_counter #(.W(16)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush), .clr(1'b0), .q(flush_cnt));
  sat_counter #(.W(16)) u_run_cnt (.clk(clk), .rst(rst), .inc(stall[0]), .clr(!stall[0]), .q(run_cnt));
  assign wd_set = stall[0] && run_cnt == 16'(STALL_TIMEOUT - 1);
  always_ff @(posedge clk)
    wd_timeout_o <= rst ? 1'b0 : wd_set ? 1'b1 : wd_clr_i ? 1'b0 : wd_timeout_o;
  always_ff @(posedge clk)
    perf_q <= rst ? '0 :
              perf_sel_i == PERF_STALL ? 32'(stall_cnt) :
              perf_sel_i == PERF_FLUSH ? 32'(flush_cnt) :
              perf_sel_i == PERF_RUN   ? 32'(run_cnt) : '0;
  assign perf_data_o = rst ? '0 : perf_q;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the five-stage core.
- Generates the 6-bit stall vector and the flush pulse consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb), plus the exception/ERET redirect PC.
- Arbitrates stall requests from IF, ID, EX and MEM (bus interfaces, multi-cycle ALU ops).
- Enforces a one-cycle post-flush recovery window, runs a stall watchdog, and keeps saturating performance counters readable by the debug/peripheral logic.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect address for every exception except ERET.
- STALL_TIMEOUT, 1024, consecutive stall[0] cycles before the watchdog trips (range 2..65535).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stallreq_from_if  in  1  fetch bus not ready.
- stallreq_from_id  in  1  load-use / branch hazard.
- stallreq_from_ex  in  1  multi-cycle madd/div in progress.
- stallreq_from_mem  in  1  data bus not ready.
- excepttype_i  in  32  final exception type from the MEM stage; 0 means none.
- cp0_epc_i  in  32  current EPC, already forwarded.
- wd_clr_i  in  1  clears the watchdog flag.
- perf_sel_i  in  2  counter select: 0 stall cycles, 1 flush count, 2 current stall run length, 3 zero.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means stop.
- flush  out  1  clears all pipeline registers.
- new_pc  out  32  redirect target; valid only while flush=1.
- wd_timeout_o  out  1  sticky watchdog flag.
- perf_data_o  out  32  selected counter, zero-extended.

Behaviour:
- Reset: FSM to RUN; every counter and wd_timeout_o cleared; stall=0, flush=0, new_pc=0, perf_data_o=0 throughout the reset cycle.
- FSM states:
  - RUN: normal operation.
  - RECOVER: exactly one cycle after any flush.
- stall, flush and new_pc are combinational from the current inputs and state (zero latency). This is required so ex_mem/mem_wb squash in the same cycle the exception is seen.
- RUN, excepttype_i != 0:
  - flush=1, stall=6'b000000.
  - new_pc = cp0_epc_i if excepttype_i == 32'h0000_000e (ERET), else EXC_VECTOR.
  - Next state RECOVER.
  - The exception wins over every simultaneous stall request.
- RUN, excepttype_i == 0: flush=0, new_pc=0. Stall priority, highest first:
  - mem → 6'b011111.
  - ex → 6'b001111.
  - id → 6'b000111.
  - if → 6'b000111.
  - none → 6'b000000.
- RECOVER: flush=0, stall=0, new_pc=0. All inputs are ignored (pipeline registers are empty). Next state RUN unconditionally. Two back-to-back flushes are therefore impossible.
- Stall run counter (16 bits):
  - Increments while stall[0]=1; clears to 0 on any cycle with stall[0]=0.
  - Saturates at 16'hFFFF.
  - When it reaches STALL_TIMEOUT-1 while stall[0]=1, wd_timeout_o sets on the next edge.
  - wd_timeout_o stays set until wd_clr_i=1 or rst. If set and clear occur in the same cycle, set wins.
- Stall-cycle counter (CNT_W): +1 per cycle with stall[0]=1; saturates at all-ones with no wrap.
- Flush counter (16 bits): +1 per flush cycle; saturates at 16'hFFFF.
- perf_data_o is registered: it reflects perf_sel_i and the counter values of the previous cycle (1-cycle read latency).
- Reset mid-stall or mid-RECOVER: immediate return to RUN with counters zero; no flush is emitted.

Decomposition:
- Shared defines.v gains:
  - exception codes EXC_INTERRUPT 32'h1, EXC_SYSCALL 32'h8, EXC_INST_INVALID 32'ha, EXC_TRAP 32'hd, EXC_OV 32'hc, EXC_ERET 32'he;
  - stall vector constants StallNone, StallFromIF_ID, StallFromEX, StallFromMEM;
  - perf select codes.
- One natural sub-module, sat_counter: a parameterised-width saturating counter with inc/clr. Instantiate it three times.

Test Plan:
- stallreq_from_ex=1 for 3 cycles, no exception → stall=6'b001111 for those 3 cycles, flush=0; after 1 more cycle, perf_sel=0 gives perf_data_o=3.
- stallreq_from_mem=1 and stallreq_from_id=1 together → stall=6'b011111 (mem priority).
- excepttype_i=32'h8 with stallreq_from_mem=1 → same cycle: flush=1, stall=0, new_pc=32'h20; next cycle: flush=0 even if excepttype_i is still 8; flush count=1.
- excepttype_i=32'he, cp0_epc_i=32'h0000_0104 → flush=1, new_pc=32'h0000_0104 for exactly one cycle.
- STALL_TIMEOUT=8, stallreq_from_if held 8 cycles → wd_timeout_o=1 on the cycle after the 8th stall cycle; stays 1 after the request drops; cleared by a wd_clr_i pulse; set and clear in the same cycle leaves it 1.
- rst asserted during a 5-cycle stall → stall=0 and all counters read 0 afterwards; no flush pulse.
